// File: rtl/lock_code_sequencer.sv
// lock_code_sequencer
// Transmit side of the switch-code interface for the combination-lock FSM.
// A small code memory holds a sequence of A/B/C symbols. When playback is
// started, the symbols are replayed onto abc_out one step per prescaler tick,
// with an optional all-zero gap tick between symbols. After the last symbol
// the block watches the lock's unlock line with a tick-based timeout and
// reports pass or fail.
//
// Ports:
//   clk        system clock
//   rst        synchronous, active-high reset (also clears the code memory)
//   tick       one-clk-wide step strobe
//   start      begin playback (accepted in IDLE or DONE only)
//   prog_we    code memory write enable (IDLE or DONE only)
//   prog_addr  code memory write address
//   prog_data  symbol to write (bit0=A, bit1=B, bit2=C)
//   len        number of symbols to play, latched on an accepted start
//   unlock_in  unlock output of the lock under test
//   abc_out    registered symbol driven to the lock A/B/C inputs
//   busy       high in DRIVE, GAP and WAIT
//   done       high in DONE
//   pass       result, valid while done=1
module lock_code_sequencer #(
  parameter int DEPTH   = 4,
  parameter int SYM_W   = 3,
  parameter int AW      = 2,
  parameter int TIMEOUT = 8,
  parameter int GAP_EN  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             start,
  input  logic             prog_we,
  input  logic [AW-1:0]    prog_addr,
  input  logic [SYM_W-1:0] prog_data,
  input  logic [AW:0]      len,
  input  logic             unlock_in,
  output logic [SYM_W-1:0] abc_out,
  output logic             busy,
  output logic             done,
  output logic             pass
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRIVE,
    S_GAP,
    S_WAIT,
    S_DONE
  } state_t;

  localparam logic [AW:0] DEPTH_V = (AW+1)'(DEPTH);
  localparam logic [7:0]  TO_V    = 8'(TIMEOUT);

  state_t           state, state_n;
  logic [SYM_W-1:0] mem [DEPTH];
  logic [AW-1:0]    idx, idx_n;
  logic [AW:0]      len_q, len_n;
  logic [7:0]       cnt, cnt_n;
  logic             early, early_n;
  logic             pass_n;
  logic [SYM_W-1:0] abc_n;

  logic [AW-1:0]    idx_inc;
  logic [7:0]       cnt_inc;
  logic             is_last;
  logic             idle_like;

  assign idx_inc   = idx + 1'b1;
  assign cnt_inc   = cnt + 8'd1;
  // len_q is never 0 outside IDLE/DONE, so len_q-1 is a valid slot index.
  assign is_last   = ({1'b0, idx} == (len_q - 1'b1));
  assign idle_like = (state == S_IDLE) || (state == S_DONE);

  assign busy = (state == S_DRIVE) || (state == S_GAP) || (state == S_WAIT);
  assign done = (state == S_DONE);

  // Code memory: cleared by reset, writable only while not playing back,
  // and out-of-range addresses are dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (prog_we && idle_like && ({1'b0, prog_addr} < DEPTH_V)) begin
      mem[prog_addr] <= prog_data;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      idx     <= '0;
      len_q   <= '0;
      cnt     <= '0;
      early   <= 1'b0;
      pass    <= 1'b0;
      abc_out <= '0;
    end else begin
      state   <= state_n;
      idx     <= idx_n;
      len_q   <= len_n;
      cnt     <= cnt_n;
      early   <= early_n;
      pass    <= pass_n;
      abc_out <= abc_n;
    end
  end

  // Next-state logic. abc_out is computed one cycle ahead so the symbol
  // appears together with the state that owns it. Ticks coinciding with an
  // accepted start are deliberately ignored because the IDLE/DONE branch
  // never looks at tick.
  always_comb begin
    state_n = state;
    idx_n   = idx;
    len_n   = len_q;
    cnt_n   = cnt;
    early_n = early;
    pass_n  = pass;
    abc_n   = abc_out;

    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          len_n   = len;
          idx_n   = '0;
          early_n = 1'b0;
          cnt_n   = '0;
          pass_n  = 1'b0;
          if ((len == '0) || (len > DEPTH_V)) begin
            state_n = S_DONE;
            abc_n   = '0;
          end else begin
            state_n = S_DRIVE;
            abc_n   = mem[0];
          end
        end
      end

      S_DRIVE: begin
        if (unlock_in) begin
          early_n = 1'b1;
        end
        if (tick) begin
          if (GAP_EN != 0) begin
            state_n = S_GAP;
            abc_n   = '0;
          end else if (is_last) begin
            state_n = S_WAIT;
            abc_n   = '0;
          end else begin
            idx_n = idx_inc;
            abc_n = mem[idx_inc];
          end
        end
      end

      S_GAP: begin
        if (unlock_in) begin
          early_n = 1'b1;
        end
        if (tick) begin
          if (is_last) begin
            state_n = S_WAIT;
            abc_n   = '0;
          end else begin
            state_n = S_DRIVE;
            idx_n   = idx_inc;
            abc_n   = mem[idx_inc];
          end
        end
      end

      // An unlock in the same cycle as the final timeout tick takes the
      // unlock path because it is tested first.
      S_WAIT: begin
        abc_n = '0;
        if (unlock_in) begin
          state_n = S_DONE;
          pass_n  = ~early;
        end else if (tick) begin
          if (cnt_inc >= TO_V) begin
            state_n = S_DONE;
            pass_n  = 1'b0;
            cnt_n   = TO_V;
          end else begin
            cnt_n = cnt_inc;
          end
        end
      end

      default: begin
        state_n = S_IDLE;
        abc_n   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_lock_code_sequencer.sv
// tb_lock_code_sequencer
// Self-checking bench for lock_code_sequencer with default parameters
// (DEPTH=4, TIMEOUT=8, GAP_EN=1). A table of {inputs, expected outputs}
// records covers programming, full playback with unlock, ignored writes and
// starts while busy, invalid lengths and early unlock. Hand-written sequences
// cover the tick-spaced timeout, unlock racing the final timeout tick, and
// reset in the middle of playback.
module tb_lock_code_sequencer;

  typedef struct {
    logic       tick;
    logic       start;
    logic [2:0] len;
    logic       unlock;
    logic       we;
    logic [1:0] addr;
    logic [2:0] data;
    logic [2:0] e_abc;
    logic       e_busy;
    logic       e_done;
    logic       e_pass;
  } vec_t;

  logic       clk;
  logic       rst;
  logic       tick;
  logic       start;
  logic       prog_we;
  logic [1:0] prog_addr;
  logic [2:0] prog_data;
  logic [2:0] len;
  logic       unlock_in;
  logic [2:0] abc_out;
  logic       busy;
  logic       done;
  logic       pass;

  int pass_count = 0;
  int total_count = 0;

  vec_t tbl[$];

  lock_code_sequencer #(
    .DEPTH(4), .SYM_W(3), .AW(2), .TIMEOUT(8), .GAP_EN(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .tick(tick),
    .start(start),
    .prog_we(prog_we),
    .prog_addr(prog_addr),
    .prog_data(prog_data),
    .len(len),
    .unlock_in(unlock_in),
    .abc_out(abc_out),
    .busy(busy),
    .done(done),
    .pass(pass)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Global time limit so the bench can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic vec_t mk(input logic t, input logic s, input logic [2:0] l,
                              input logic u, input logic w, input logic [1:0] a,
                              input logic [2:0] d, input logic [2:0] abc,
                              input logic b, input logic dn, input logic p);
    vec_t v;
    v.tick = t; v.start = s; v.len = l; v.unlock = u;
    v.we = w; v.addr = a; v.data = d;
    v.e_abc = abc; v.e_busy = b; v.e_done = dn; v.e_pass = p;
    return v;
  endfunction

  // Drive one cycle's inputs just after a rising edge, then step past the
  // next rising edge so outputs can be sampled away from it.
  task automatic applyStimulus(input vec_t v);
    tick      = v.tick;
    start     = v.start;
    len       = v.len;
    unlock_in = v.unlock;
    prog_we   = v.we;
    prog_addr = v.addr;
    prog_data = v.data;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input int act, input int exp);
    total_count++;
    if (act == exp) begin
      pass_count++;
    end else begin
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic checkAll(input string name, input int e_abc, input int e_busy,
                          input int e_done, input int e_pass);
    checkOutput({name, ".abc"},  int'(abc_out), e_abc);
    checkOutput({name, ".busy"}, int'(busy),    e_busy);
    checkOutput({name, ".done"}, int'(done),    e_done);
    checkOutput({name, ".pass"}, int'(pass),    e_pass);
  endtask

  // One tick preceded by four quiet cycles: a tick every 5 clk.
  task automatic spacedTick(input logic u_on_tick);
    repeat (4) applyStimulus(mk(0,0,0,0,0,0,0, 0,0,0,0));
    applyStimulus(mk(1,0,0,u_on_tick,0,0,0, 0,0,0,0));
  endtask

  initial begin
    rst = 1'b1;
    tick = 0; start = 0; len = 0; unlock_in = 0;
    prog_we = 0; prog_addr = 0; prog_data = 0;
    repeat (2) @(posedge clk);
    #1;
    checkAll("reset", 0, 0, 0, 0);
    rst = 1'b0;

    //                 t s len u we a d   abc b d p
    tbl.push_back(mk(0,0,0,0,1,0,1, 0,0,0,0)); // program mem = {1,2,4,1}
    tbl.push_back(mk(0,0,0,0,1,1,2, 0,0,0,0));
    tbl.push_back(mk(0,0,0,0,1,2,4, 0,0,0,0));
    tbl.push_back(mk(0,0,0,0,1,3,1, 0,0,0,0));
    tbl.push_back(mk(0,1,4,0,0,0,0, 1,1,0,0)); // start len=DEPTH
    tbl.push_back(mk(0,0,0,0,1,2,3, 1,1,0,0)); // write while busy ignored
    tbl.push_back(mk(1,0,0,0,0,0,0, 0,1,0,0)); // gap
    tbl.push_back(mk(1,1,1,0,1,0,7, 2,1,0,0)); // start+write while busy ignored
    tbl.push_back(mk(1,0,0,0,0,0,0, 0,1,0,0));
    tbl.push_back(mk(1,0,0,0,0,0,0, 4,1,0,0)); // mem[2] kept its value
    tbl.push_back(mk(1,0,0,0,0,0,0, 0,1,0,0));
    tbl.push_back(mk(1,0,0,0,0,0,0, 1,1,0,0));
    tbl.push_back(mk(1,0,0,0,0,0,0, 0,1,0,0));
    tbl.push_back(mk(1,0,0,0,0,0,0, 0,1,0,0)); // into WAIT
    tbl.push_back(mk(0,0,0,0,0,0,0, 0,1,0,0));
    tbl.push_back(mk(0,0,0,1,0,0,0, 0,0,1,1)); // unlock -> pass
    tbl.push_back(mk(0,0,0,0,0,0,0, 0,0,1,1)); // pass held
    tbl.push_back(mk(1,1,1,0,0,0,0, 1,1,0,0)); // tick with start ignored; mem[0]=1
    tbl.push_back(mk(1,0,0,0,0,0,0, 0,1,0,0));
    tbl.push_back(mk(1,0,0,0,0,0,0, 0,1,0,0)); // WAIT after single symbol
    tbl.push_back(mk(0,1,2,0,0,0,0, 0,1,0,0)); // start in WAIT ignored
    tbl.push_back(mk(0,0,0,1,0,0,0, 0,0,1,1));
    tbl.push_back(mk(0,1,0,0,0,0,0, 0,0,1,0)); // len=0 -> DONE fail
    tbl.push_back(mk(0,1,5,0,0,0,0, 0,0,1,0)); // len>DEPTH -> DONE fail
    tbl.push_back(mk(0,1,2,0,0,0,0, 1,1,0,0));
    tbl.push_back(mk(1,0,0,0,0,0,0, 0,1,0,0));
    tbl.push_back(mk(1,0,0,0,0,0,0, 2,1,0,0));
    tbl.push_back(mk(0,0,0,1,0,0,0, 2,1,0,0)); // early unlock, playback unchanged
    tbl.push_back(mk(1,0,0,0,0,0,0, 0,1,0,0));
    tbl.push_back(mk(1,0,0,0,0,0,0, 0,1,0,0)); // WAIT
    tbl.push_back(mk(0,0,0,1,0,0,0, 0,0,1,0)); // unlock after early -> fail

    for (int i = 0; i < tbl.size(); i++) begin
      applyStimulus(tbl[i]);
      checkAll($sformatf("v%0d", i), int'(tbl[i].e_abc), int'(tbl[i].e_busy),
               int'(tbl[i].e_done), int'(tbl[i].e_pass));
    end

    // Timeout: no unlock, ticks every 5 clk, done exactly on the 8th WAIT tick.
    applyStimulus(mk(0,1,1,0,0,0,0, 0,0,0,0));
    checkAll("to_start", 1, 1, 0, 0);
    spacedTick(1'b0);
    checkAll("to_gap", 0, 1, 0, 0);
    spacedTick(1'b0);
    checkAll("to_wait", 0, 1, 0, 0);
    for (int k = 1; k <= 7; k++) begin
      spacedTick(1'b0);
      checkAll($sformatf("to_tick%0d", k), 0, 1, 0, 0);
    end
    spacedTick(1'b0);
    checkAll("to_tick8", 0, 0, 1, 0);

    // Unlock in the same cycle as the final timeout tick wins.
    applyStimulus(mk(0,1,1,0,0,0,0, 0,0,0,0));
    checkAll("race_start", 1, 1, 0, 0);
    applyStimulus(mk(1,0,0,0,0,0,0, 0,0,0,0));
    applyStimulus(mk(1,0,0,0,0,0,0, 0,0,0,0));
    for (int k = 1; k <= 7; k++) begin
      applyStimulus(mk(1,0,0,0,0,0,0, 0,0,0,0));
    end
    checkAll("race_pre", 0, 1, 0, 0);
    applyStimulus(mk(1,0,0,1,0,0,0, 0,0,0,0));
    checkAll("race_final", 0, 0, 1, 1);

    // Reset during the third symbol aborts playback and clears memory.
    applyStimulus(mk(0,1,4,0,0,0,0, 0,0,0,0));
    checkAll("rst_s1", 1, 1, 0, 0);
    applyStimulus(mk(1,0,0,0,0,0,0, 0,0,0,0));
    applyStimulus(mk(1,0,0,0,0,0,0, 0,0,0,0));
    applyStimulus(mk(1,0,0,0,0,0,0, 0,0,0,0));
    applyStimulus(mk(1,0,0,0,0,0,0, 0,0,0,0));
    checkAll("rst_s3", 4, 1, 0, 0);
    rst = 1'b1;
    applyStimulus(mk(1,1,1,1,1,0,5, 0,0,0,0));
    rst = 1'b0;
    checkAll("rst_abort", 0, 0, 0, 0);
    applyStimulus(mk(0,1,1,0,0,0,0, 0,0,0,0));
    checkAll("rst_replay", 0, 1, 0, 0);

    $display("%0d/%0d checks passed", pass_count, total_count);
    $finish;
  end

endmodule

// File: doc/lock_code_sequencer.md
Name: lock_code_sequencer

Overview:
- Transmit side of the switch-code interface consumed by the combination-lock FSM.
- Replays a programmed sequence of 3-bit A/B/C symbols onto abc_out, advancing one step per prescaler tick.
- After the last symbol, watches the lock's unlock line with a tick-based timeout and reports pass or fail.
- Used for automated lock self-test and as an auto-entry "key" alongside the manual switch path.

Parameters:
- DEPTH, 4, number of symbol slots in the code memory (2..16).
- SYM_W, 3, symbol width; bit0=A, bit1=B, bit2=C.
- AW, 2, address/length width; must satisfy 2^AW >= DEPTH.
- TIMEOUT, 8, ticks to wait for unlock after the last symbol (1..255).
- GAP_EN, 1, 1 = drive all-zero for one tick between consecutive symbols.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- tick  input  1  one-clk-wide step strobe from the prescaler domain-equivalent enable.
- start  input  1  begin playback; sampled every clk.
- prog_we  input  1  code memory write enable.
- prog_addr  input  AW  code memory write address.
- prog_data  input  SYM_W  symbol to write.
- len  input  AW+1  number of symbols to play; latched on accepted start.
- unlock_in  input  1  unlock output of the lock under test.
- abc_out  output  SYM_W  registered symbol driven to the lock A/B/C inputs.
- busy  output  1  high in DRIVE, GAP and WAIT.
- done  output  1  high in DONE.
- pass  output  1  result, valid while done=1.

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE; abc_out=0; busy=0; done=0; pass=0.
  - idx=0, timeout counter=0, early flag=0.
  - All memory slots are cleared to 0.
  - rst overrides every other input and aborts playback mid-sequence; abc_out reads 0 on the next cycle.
- Memory writes:
  - prog_we=1 writes mem[prog_addr]=prog_data at the clk edge, in IDLE or DONE only.
  - Ignored while busy=1.
  - Ignored when prog_addr >= DEPTH.
- States: IDLE, DRIVE, GAP, WAIT, DONE.
- IDLE/DONE with start=1:
  - Latch len. Set idx=0, clear the early flag and the counter, clear done and pass.
  - If len=0 or len>DEPTH: go to DONE with pass=0 next cycle.
  - Otherwise go to DRIVE with abc_out=mem[0] on the next cycle (1-cycle latency, busy=1 together with it).
  - A tick in the same cycle as start is ignored.
- Start handling outside IDLE/DONE: start while busy=1 is ignored.
- DRIVE: abc_out holds mem[idx]. On tick:
  - If GAP_EN=1: go to GAP with abc_out=0.
  - Else if idx=len-1: go to WAIT with abc_out=0.
  - Else: idx+1, abc_out=mem[idx+1], stay in DRIVE.
- GAP: abc_out=0. On tick:
  - If idx=len-1: go to WAIT.
  - Else: idx+1 and DRIVE with abc_out=mem[idx+1].
- Early unlock: unlock_in=1 in any DRIVE or GAP cycle sets the early flag. Playback continues unchanged.
- WAIT:
  - abc_out=0; the counter increments on each tick.
  - If unlock_in=1 in any WAIT cycle: go to DONE, pass = NOT early.
  - Else when a tick brings the counter to TIMEOUT: go to DONE, pass=0.
  - If unlock_in=1 and the final tick occur in the same cycle, unlock wins.
- DONE: done=1, busy=0, abc_out=0, pass held until the next accepted start or rst.
- Tick rate: each symbol is held for exactly one tick interval. The first symbol's hold runs from entry to the first tick after entry, so it may be shorter than a full interval.
- Widths: the counter is 8 bits wide and saturates at TIMEOUT; idx is AW bits wide and never wraps because it is bounded by len-1.

Test Plan:
- Program mem={1,2,4,1}, len=4, GAP_EN=1, tick every 5 clk, lock model asserts unlock 2 clk after the final symbol -> abc_out sequence 1,0,2,0,4,0,1,0; done=1 with pass=1; busy falls together with done.
- Same program, lock model never unlocks, TIMEOUT=8 -> done=1 and pass=0 exactly 8 ticks after entering WAIT; abc_out=0 throughout WAIT.
- unlock_in pulsed during the second symbol and again in WAIT -> done=1 with pass=0 (early flag set).
- Start with len=0, then start with len=5 (DEPTH=4) -> DONE with pass=0 the next cycle in both cases; no symbol is driven.
- Assert rst during the third symbol -> next cycle abc_out=0, state IDLE, busy=0, done=0; mem reads 0 on a replay started with len=1.
- prog_we while busy, and start while busy -> memory contents unchanged (checked by a replay) and the current sequence is unaffected.
